maze_probe_scheduler: RTL
=========================

MAZE_PROBE_SCHEDULER -- requirements
Module: maze_probe_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NREQ, 5, number of requesters (index 0 = pacman, 1..4 = ghosts)
- SF, 60, tile size in pixels
- S_X, 150, maze pixel origin x
- S_Y, 34, maze pixel origin y
- P_W, 15, horizontal probe offset
- P_H, 15, vertical probe offset
- ROWS, 8, maze rows
- COLS, 8, maze columns

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; rising edge
- rst_n, in, 1, asynchronous active-low reset
- req, in, NREQ, per-requester level request; held until gnt
- req_xpos, in, NREQ*10, packed x pixel per requester
- req_ypos, in, NREQ*10, packed y pixel per requester
- req_dir, in, NREQ*4, packed direction per requester
- gnt, out, NREQ, one-hot 1-cycle acceptance pulse
- wall_rd_en, out, 1, wall ROM read strobe
- wall_addr, out, 6, row*COLS+col
- wall_data, in, 1, ROM wall bit, valid 1 cycle after wall_rd_en
- resp_valid, out, 1, 1-cycle result pulse
- resp_id, out, 3, requester index of the result
- resp_row, out, 8, probed tile row
- resp_col, out, 8, probed tile column
- resp_blocked, out, 1, 1 = wall or out-of-bounds
- resp_oob, out, 1, 1 = probe outside the maze
- busy, out, 1, high in every state except IDLE

Function
REQ-003 The FSM SHALL have states IDLE, DIV, ADDR, WAIT and RESP; the ARB step SHALL occur in IDLE.
REQ-004 In IDLE with any req bit set, the block SHALL grant round-robin, starting after the last-granted index (initially index NREQ-1, so index 0 has first priority); gnt pulses the same cycle; the block SHALL latch x, y, dir and id; next state is DIV.
REQ-005 Direction SHALL be decoded with priority bit3 left > bit2 up > bit1 right > bit0 down; 4'b0000 = stopped.
REQ-006 Probe offsets SHALL be px = x-S_X, py = y-S_Y, modified as follows: left px-P_W, right px+P_W, up py-P_H, down py+P_H; stopped adds no offset.
REQ-007 Arithmetic SHALL be 11-bit signed; a negative px or py SHALL set oob=1, blocked=1, row=col=0 and go directly to RESP.
REQ-008 DIV SHALL work by repeated subtraction on both remainders in parallel. In each DIV cycle, each remainder >= SF is reduced by SF and its 4-bit quotient is incremented. The cycle in which both remainders are < SF SHALL exit DIV.
REQ-009 A quotient reaching 15, or final row >= ROWS or col >= COLS, SHALL set oob=1 and blocked=1; the block SHALL then go to RESP, skipping ADDR and WAIT.
REQ-010 In ADDR, the block SHALL assert wall_rd_en for exactly 1 cycle with wall_addr = row*COLS+col. In WAIT, it SHALL capture wall_data, with blocked = wall_data and oob = 0.
REQ-011 In RESP, the block SHALL pulse resp_valid for 1 cycle with registered id, row, col, blocked and oob, then return to IDLE. No new grant SHALL be issued in the RESP cycle.
REQ-012 In-bounds latency SHALL be resp_valid exactly max(q_row,q_col)+4 cycles after gnt.
REQ-013 The negative-offset case (REQ-007) SHALL have a latency of 1 cycle after gnt.
REQ-014 Requests arriving while busy SHALL be ignored until IDLE. Deasserting req before gnt withdraws the request with no side effect.
REQ-015 The block SHALL have at most one transaction in flight; gnt SHALL never pulse while busy=1.

Reset
REQ-016 While rst_n=0, the block SHALL be in state IDLE with the round-robin pointer = NREQ-1.
REQ-017 While rst_n=0, all outputs (gnt, wall_rd_en, wall_addr, resp_*, busy) SHALL be 0.
REQ-018 Reset asserted mid-transaction SHALL abort it with no resp_valid; the first grant after release SHALL go to index 0 if it is requesting.

Verification
REQ-019 req0 stopped, x=195, y=94 -> gnt=00001, wall_addr=8, wall_data=0, resp row=1, col=0, blocked=0, resp_valid 5 cycles after gnt.
REQ-020 req1 right, x=600, y=34, wall_data=1 -> resp row=0, col=7, blocked=1, oob=0, wall_addr=7, latency 11.
REQ-021 req2 left, x=160, y=100 -> px=-5, oob=1, blocked=1, no wall_rd_en, resp 1 cycle after gnt.
REQ-022 req3 down, x=200, y=540 -> row quotient 8 >= ROWS, oob=1, no wall_rd_en, resp 10 cycles after gnt.
REQ-023 req=10001 held from reset -> grant order 0, 4, 0, 4; resp_id matches each grant; at most one grant per transaction.
REQ-024 rst_n pulsed low during DIV -> resp_valid stays 0, busy=0 immediately; after release with req=00011, first gnt=00001.

Source files
------------

// File: rtl/maze_probe_scheduler.sv
// Round-robin tile probe: grant, offset, divide, wall ROM lookup, one result pulse per request.
// Latency max(q_row,q_col)+4 after gnt (1 if negative, +2 if off-maze); requests are ignored while busy.
module maze_probe_scheduler #(
  parameter int NREQ = 5,
  parameter int SF   = 60,
  parameter int S_X  = 150,
  parameter int S_Y  = 34,
  parameter int P_W  = 15,
  parameter int P_H  = 15,
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*10-1:0] req_xpos,
  input  logic [NREQ*10-1:0] req_ypos,
  input  logic [NREQ*4-1:0]  req_dir,
  output logic [NREQ-1:0]    gnt,
  output logic               wall_rd_en,
  output logic [5:0]         wall_addr,
  input  logic               wall_data,
  output logic               resp_valid,
  output logic [2:0]         resp_id,
  output logic [7:0]         resp_row,
  output logic [7:0]         resp_col,
  output logic               resp_blocked,
  output logic               resp_oob,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, DIV, ADDR, WAIT, RESP} state_t;

  localparam logic [10:0] SF_W = 11'(SF);

  state_t      st, st_nxt;
  logic        armed;
  logic [2:0]  ptr, sel, cand;
  logic        any_req, take;
  logic [9:0]  sel_x, sel_y;
  logic [3:0]  sel_dir;
  logic [10:0] px, py;
  logic        neg;
  logic [2:0]  id_q;
  logic [10:0] rem_x, rem_y;
  logic [3:0]  q_row, q_col;
  logic        blocked_q, oob_q;
  logic        div_done, div_sat, in_bounds;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    sel     = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = 3'((int'(ptr) + i) % NREQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        sel     = cand;
      end
    end
  end

  always_comb begin
    sel_x   = req_xpos[int'(sel)*10 +: 10];
    sel_y   = req_ypos[int'(sel)*10 +: 10];
    sel_dir = req_dir[int'(sel)*4 +: 4];
    px      = {1'b0, sel_x} - 11'(S_X);
    py      = {1'b0, sel_y} - 11'(S_Y);
    if (sel_dir[3])      px = px - 11'(P_W);
    else if (sel_dir[2]) py = py - 11'(P_H);
    else if (sel_dir[1]) px = px + 11'(P_W);
    else if (sel_dir[0]) py = py + 11'(P_H);
    neg = px[10] | py[10];
  end

  // armed holds off grants for the first cycle after reset release.
  assign take      = (st == IDLE) && armed && any_req;
  assign div_done  = (rem_x < SF_W) && (rem_y < SF_W);
  assign div_sat   = (q_row == 4'd15) || (q_col == 4'd15);
  assign in_bounds = (int'(q_row) < ROWS) && (int'(q_col) < COLS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE: if (take) st_nxt = neg ? RESP : DIV;
      DIV: begin
        if (div_sat)       st_nxt = RESP;
        else if (div_done) st_nxt = in_bounds ? ADDR : RESP;
      end
      ADDR:    st_nxt = WAIT;
      WAIT:    st_nxt = RESP;
      RESP:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (take) gnt[sel] = 1'b1;
    busy       = (st != IDLE);
    wall_rd_en = (st == ADDR);
    wall_addr  = (st == ADDR) ? (6'(q_row) * 6'(COLS) + 6'(q_col)) : 6'd0;
    resp_valid = (st == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      ptr       <= 3'(NREQ - 1);
      id_q      <= '0;
      rem_x     <= '0;
      rem_y     <= '0;
      q_row     <= '0;
      q_col     <= '0;
      blocked_q <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (st)
        IDLE: begin
          if (take) begin
            ptr   <= sel;
            id_q  <= sel;
            q_row <= '0;
            q_col <= '0;
            if (neg) begin
              rem_x     <= '0;
              rem_y     <= '0;
              oob_q     <= 1'b1;
              blocked_q <= 1'b1;
            end else begin
              rem_x     <= px;
              rem_y     <= py;
              oob_q     <= 1'b0;
              blocked_q <= 1'b0;
            end
          end
        end
        DIV: begin
          if (div_sat || (div_done && !in_bounds)) begin
            oob_q     <= 1'b1;
            blocked_q <= 1'b1;
          end else if (!div_done) begin
            if (rem_x >= SF_W) begin
              rem_x <= rem_x - SF_W;
              q_col <= q_col + 4'd1;
            end
            if (rem_y >= SF_W) begin
              rem_y <= rem_y - SF_W;
              q_row <= q_row + 4'd1;
            end
          end
        end
        WAIT: begin
          blocked_q <= wall_data;
          oob_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_id      = id_q;
  assign resp_row     = {4'b0000, q_row};
  assign resp_col     = {4'b0000, q_col};
  assign resp_blocked = blocked_q;
  assign resp_oob     = oob_q;

endmodule
